// File: rtl/processor_nios2_qsys_0_oci_dct_packer.sv
// processor_nios2_qsys_0_oci_dct_packer
//
// Data-trace (DCT) packer for the Nios II OCI debug path. Incoming trace
// slots are gathered into a SLOTS-wide frame. Each complete frame moves into
// a one-frame holding register, and the downstream consumer drains that
// register over a valid/ready handshake. An end-of-test flush pushes out any
// partial frame and then reports completion. Slots that arrive while the
// packer is full are counted by a saturating drop counter.
//
// Ports
//   clk            : sole clock, rising edge
//   reset          : synchronous, active-high
//   dct_in_valid   : a trace slot is present this cycle (no back-pressure)
//   dct_in_data    : trace slot payload
//   dct_buffer     : frame currently being accumulated (debug view)
//   dct_count      : number of slots in dct_buffer
//   out_valid      : holding register contains a frame
//   out_data       : held frame; unfilled slots read as zero
//   out_slots      : number of valid slots in out_data
//   out_ready      : consumer takes the frame when out_valid && out_ready
//   test_ending    : flush request
//   test_has_ended : flush finished; stays set until reset
//   drop_count     : number of discarded slots, saturating
module processor_nios2_qsys_0_oci_dct_packer #(
  parameter int SLOT_W         = 6,
  parameter int SLOTS          = 5,
  parameter int COUNT_W        = 4,
  parameter int DROP_W         = 8,
  parameter int PACK_MSB_FIRST = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dct_in_valid,
  input  logic [SLOT_W-1:0]         dct_in_data,
  output logic [SLOT_W*SLOTS-1:0]   dct_buffer,
  output logic [COUNT_W-1:0]        dct_count,
  output logic                      out_valid,
  output logic [SLOT_W*SLOTS-1:0]   out_data,
  output logic [COUNT_W-1:0]        out_slots,
  input  logic                      out_ready,
  input  logic                      test_ending,
  output logic                      test_has_ended,
  output logic [DROP_W-1:0]         drop_count
);

  localparam int FW = SLOT_W * SLOTS;
  localparam logic [COUNT_W-1:0] SLOTS_C = COUNT_W'(SLOTS);

  typedef enum logic [1:0] {
    ST_CAPTURE,
    ST_FLUSH,
    ST_ENDED
  } state_t;

  state_t              state_q, state_d;
  logic [FW-1:0]       dct_buffer_q, dct_buffer_d;
  logic [COUNT_W-1:0]  dct_count_q, dct_count_d;
  logic                out_valid_q, out_valid_d;
  logic [FW-1:0]       out_data_q, out_data_d;
  logic [COUNT_W-1:0]  out_slots_q, out_slots_d;
  logic [DROP_W-1:0]   drop_count_q, drop_count_d;

  logic hold_free;
  logic handshake;

  // Returns buf_in with data written into the slot for fill count cnt. With
  // MSB-first packing the first slot of a frame occupies the top slot.
  function automatic logic [FW-1:0] write_slot(input logic [FW-1:0]      buf_in,
                                               input logic [COUNT_W-1:0] cnt,
                                               input logic [SLOT_W-1:0]  data);
    logic [FW-1:0] r;
    r = buf_in;
    for (int i = 0; i < SLOTS; i++) begin
      if (int'(cnt) == ((PACK_MSB_FIRST != 0) ? (SLOTS - 1 - i) : i)) begin
        r[i*SLOT_W +: SLOT_W] = data;
      end
    end
    return r;
  endfunction

  assign hold_free = !out_valid_q || out_ready;
  assign handshake = out_valid_q && out_ready;

  // Next-state logic. The holding register is released by the handshake
  // unless a move refills it in the same cycle. A move always empties the
  // accumulator, so an input that arrives with the move becomes slot 0 of
  // the next frame. This is how full-rate streaming avoids drops.
  always_comb begin
    state_d      = state_q;
    dct_buffer_d = dct_buffer_q;
    dct_count_d  = dct_count_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_slots_d  = out_slots_q;
    drop_count_d = drop_count_q;

    if (handshake) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_CAPTURE: begin
        if (dct_count_q == SLOTS_C && hold_free) begin
          out_data_d  = dct_buffer_q;
          out_slots_d = SLOTS_C;
          out_valid_d = 1'b1;
          if (dct_in_valid) begin
            dct_buffer_d = write_slot('0, '0, dct_in_data);
            dct_count_d  = COUNT_W'(1);
          end else begin
            dct_buffer_d = '0;
            dct_count_d  = '0;
          end
        end else if (dct_in_valid) begin
          if (dct_count_q < SLOTS_C) begin
            dct_buffer_d = write_slot(dct_buffer_q, dct_count_q, dct_in_data);
            dct_count_d  = dct_count_q + COUNT_W'(1);
          end else if (!(&drop_count_q)) begin
            drop_count_d = drop_count_q + DROP_W'(1);
          end
        end
        if (test_ending) begin
          state_d = ST_FLUSH;
        end
      end

      // During the flush, inputs are ignored and do not count as drops.
      // Completion waits until the accumulator and the hold are both empty.
      ST_FLUSH: begin
        if (dct_count_q != '0 && hold_free) begin
          out_data_d   = dct_buffer_q;
          out_slots_d  = dct_count_q;
          out_valid_d  = 1'b1;
          dct_buffer_d = '0;
          dct_count_d  = '0;
        end else if (dct_count_q == '0 && !out_valid_q) begin
          state_d = ST_ENDED;
        end
      end

      ST_ENDED: begin
      end

      default: begin
        state_d = ST_CAPTURE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_CAPTURE;
      dct_buffer_q <= '0;
      dct_count_q  <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_slots_q  <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      dct_buffer_q <= dct_buffer_d;
      dct_count_q  <= dct_count_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_slots_q  <= out_slots_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign dct_buffer     = dct_buffer_q;
  assign dct_count      = dct_count_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_slots      = out_slots_q;
  assign drop_count     = drop_count_q;
  assign test_has_ended = (state_q == ST_ENDED);

endmodule
